// File: rtl/tdm_demux_if.sv
// Bus bundle for the TDM demultiplexer: serialized input beat plus the
// per-channel parallel outputs and frame status.
interface tdm_demux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_sof;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_valid;
    logic                     frame_done;
    logic                     sync_err;
    logic                     locked;

    modport master (
        output in_valid, in_data, in_sof,
        input  out_data, out_valid, frame_done, sync_err, locked
    );

    modport slave (
        input  in_valid, in_data, in_sof,
        output out_data, out_valid, frame_done, sync_err, locked
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: routes a serialized channel stream (sof on channel 0)
// to registered per-channel outputs, tracking frame alignment.
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_if.slave  bus
);
    localparam int                CNT_W   = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

    typedef enum logic {
        S_HUNT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_ch_cnt;
    logic [NUM_CH*DATA_W-1:0] r_out_data;
    logic [NUM_CH-1:0]        r_out_valid;
    logic                     r_frame_done;
    logic                     r_sync_err;
    logic                     r_locked;

    logic                     w_wr;
    logic [CNT_W-1:0]         w_wr_idx;
    logic                     w_err;
    logic                     w_done;
    logic [CNT_W-1:0]         w_cnt_nxt;
    state_t                   w_state_nxt;

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] c);
        return (c == LAST_CH) ? '0 : c + 1'b1;
    endfunction

    // Decide what the current beat does: which channel (if any) it writes,
    // and whether it breaks alignment.
    always_comb begin
        w_wr        = 1'b0;
        w_wr_idx    = r_ch_cnt;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_cnt_nxt   = r_ch_cnt;
        w_state_nxt = r_state;
        if (bus.in_valid) begin
            if (r_state == S_HUNT) begin
                if (bus.in_sof) begin
                    w_wr        = 1'b1;
                    w_wr_idx    = '0;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_RUN;
                end
            end else if (bus.in_sof) begin
                // An sof anywhere but slot 0 truncates the frame; resync on it.
                w_wr      = 1'b1;
                w_wr_idx  = '0;
                w_cnt_nxt = CNT_W'(1);
                w_err     = (r_ch_cnt != '0);
            end else if (r_ch_cnt == '0) begin
                w_err       = 1'b1;
                w_state_nxt = S_HUNT;
            end else begin
                w_wr      = 1'b1;
                w_done    = (r_ch_cnt == LAST_CH);
                w_cnt_nxt = wrap_inc(r_ch_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_locked     <= 1'b0;
            r_ch_cnt     <= '0;
            r_out_data   <= '0;
            r_out_valid  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_locked     <= (w_state_nxt == S_RUN);
            r_ch_cnt     <= w_cnt_nxt;
            r_frame_done <= w_done;
            r_sync_err   <= w_err;
            for (int k = 0; k < NUM_CH; k++) begin
                r_out_valid[k] <= w_wr && (w_wr_idx == CNT_W'(k));
                if (w_wr && (w_wr_idx == CNT_W'(k)))
                    r_out_data[k*DATA_W +: DATA_W] <= bus.in_data;
            end
        end
    end

    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.sync_err   = r_sync_err;
    assign bus.locked     = r_locked;
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frames with literal expectations, then random
// beats with occasional misalignment and resets, all compared to a frame model.
module tb_tdm_demux;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdm_demux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    // Frame-level model: remembers whether we are aligned and which slot
    // the next beat belongs to; holds channel samples in a plain array.
    bit                m_locked;
    int                m_pos;
    logic [DATA_W-1:0] m_ch [NUM_CH];
    logic [NUM_CH-1:0] m_valid;
    bit                m_done;
    bit                m_err;

    always @(posedge clk) begin
        m_valid = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            m_locked = 1'b0;
            m_pos    = 0;
            for (int k = 0; k < NUM_CH; k++) m_ch[k] = '0;
        end else if (bus.in_valid) begin
            if (bus.in_sof) begin
                if (m_locked && m_pos != 0) m_err = 1'b1;
                m_ch[0]    = bus.in_data;
                m_valid[0] = 1'b1;
                m_pos      = 1;
                m_locked   = 1'b1;
            end else if (m_locked) begin
                if (m_pos == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_ch[m_pos]    = bus.in_data;
                    m_valid[m_pos] = 1'b1;
                    m_done         = (m_pos == NUM_CH - 1);
                    m_pos          = (m_pos + 1) % NUM_CH;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < NUM_CH; k++)
                chk($sformatf("model ch%0d", k), 64'(bus.out_data[k*DATA_W +: DATA_W]), 64'(m_ch[k]));
            chk("model out_valid",  64'(bus.out_valid),  64'(m_valid));
            chk("model frame_done", 64'(bus.frame_done), 64'(m_done));
            chk("model sync_err",   64'(bus.sync_err),   64'(m_err));
            chk("model locked",     64'(bus.locked),     64'(m_locked));
        end
    end

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit s, input bit r);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_sof   = s;
        rst          = r;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input bit s);
        drive(1'b1, d, s, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle(1);
    endtask

    int up_pos;
    bit v, s;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sof   = 1'b0;
        do_reset();
        cmp_en = 1'b1;
        chk("reset out_data",  64'(bus.out_data),  64'h0);
        chk("reset out_valid", 64'(bus.out_valid), 64'h0);
        chk("reset locked",    64'(bus.locked),    64'h0);

        // Back-to-back frame.
        beat(8'hA0, 1'b1); beat(8'hA1, 1'b0); beat(8'hA2, 1'b0); beat(8'hA3, 1'b0);
        idle(1);
        chk("frame out_data",   64'(bus.out_data),   64'hA3A2A1A0);
        chk("frame out_valid",  64'(bus.out_valid),  64'h8);
        chk("frame frame_done", 64'(bus.frame_done), 64'h1);
        chk("frame locked",     64'(bus.locked),     64'h1);

        // Hunt drops non-sof beats silently.
        do_reset();
        beat(8'h11, 1'b0); beat(8'h22, 1'b0);
        idle(1);
        chk("hunt drop sync_err", 64'(bus.sync_err), 64'h0);
        chk("hunt drop locked",   64'(bus.locked),   64'h0);
        beat(8'h33, 1'b1);
        idle(1);
        chk("hunt lock out_data",  64'(bus.out_data),  64'h00000033);
        chk("hunt lock out_valid", 64'(bus.out_valid), 64'h1);
        chk("hunt lock locked",    64'(bus.locked),    64'h1);

        // Early sof truncates the frame.
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0);
        beat(8'h10, 1'b1); beat(8'h20, 1'b0); beat(8'h55, 1'b1);
        idle(1);
        chk("early sof sync_err",   64'(bus.sync_err),   64'h1);
        chk("early sof out_valid",  64'(bus.out_valid),  64'h1);
        chk("early sof frame_done", 64'(bus.frame_done), 64'h0);
        chk("early sof out_data",   64'(bus.out_data),   64'h03022055);
        beat(8'h66, 1'b0);
        idle(1);
        chk("resync ch1 out_data",  64'(bus.out_data),  64'h03026655);
        chk("resync ch1 out_valid", 64'(bus.out_valid), 64'h2);

        // Missing sof drops lock.
        beat(8'h77, 1'b0); beat(8'h88, 1'b0); beat(8'h77, 1'b0);
        idle(1);
        chk("missing sof sync_err", 64'(bus.sync_err),  64'h1);
        chk("missing sof locked",   64'(bus.locked),    64'h0);
        chk("missing sof out_valid",64'(bus.out_valid), 64'h0);
        chk("missing sof out_data", 64'(bus.out_data),  64'h88776655);
        beat(8'h99, 1'b1);
        idle(1);
        chk("relock out_data", 64'(bus.out_data), 64'h88776699);
        chk("relock locked",   64'(bus.locked),   64'h1);

        // Gapped frame: valid pattern 1,0,0,1,1,0,1.
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0);
        beat(8'hB0, 1'b1); idle(2); beat(8'hB1, 1'b0); beat(8'hB2, 1'b0); idle(1); beat(8'hB3, 1'b0);
        idle(1);
        chk("gap out_data",   64'(bus.out_data),   64'hB3B2B1B0);
        chk("gap frame_done", 64'(bus.frame_done), 64'h1);
        idle(1);
        chk("gap strobe clear", 64'(bus.frame_done), 64'h0);

        // Reset lands on the ch2 beat.
        beat(8'hC0, 1'b1); beat(8'hC1, 1'b0);
        drive(1'b1, 8'hC2, 1'b0, 1'b1);
        idle(1);
        chk("mid reset out_data",  64'(bus.out_data),  64'h0);
        chk("mid reset out_valid", 64'(bus.out_valid), 64'h0);
        chk("mid reset locked",    64'(bus.locked),    64'h0);
        beat(8'hD0, 1'b1); beat(8'hD1, 1'b0); beat(8'hD2, 1'b0); beat(8'hD3, 1'b0);
        idle(1);
        chk("post reset out_data",   64'(bus.out_data),   64'hD3D2D1D0);
        chk("post reset frame_done", 64'(bus.frame_done), 64'h1);

        // Random stream: upstream mostly aligned, with injected sof errors.
        up_pos = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399, 0) == 0) begin
                drive(($urandom_range(1, 0) == 1), DATA_W'($urandom), 1'b0, 1'b1);
                up_pos = 0;
            end else begin
                v = ($urandom_range(2, 0) != 0);
                s = (up_pos == 0);
                if ($urandom_range(15, 0) == 0) s = !s;
                drive(v, DATA_W'($urandom), s, 1'b0);
                if (v) up_pos = s ? 1 : (up_pos + 1) % NUM_CH;
            end
        end
        idle(2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of a select-driven N:1 mux stream.
- Takes one serialized sample stream, where an upstream mux cycles its select through channels 0..NUM_CH-1 and flags channel 0 with a start-of-frame marker.
- Routes each sample to a registered per-channel output with a one-cycle valid strobe.
- Tracks frame alignment and flags sync loss.

Parameters:
- NUM_CH, 4, number of channels per frame (legal range ≥2).
- DATA_W, 8, sample width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data/in_sof qualify this cycle (one beat).
- in_data  input  DATA_W  serialized sample.
- in_sof  input  1  beat is channel 0 of a frame; ignored when in_valid=0.
- out_data  output  NUM_CH*DATA_W  channel k sample at bits [k*DATA_W +: DATA_W]; holds last value.
- out_valid  output  NUM_CH  bit k pulses one cycle when channel k is updated.
- frame_done  output  1  one-cycle pulse when channel NUM_CH-1 is updated.
- sync_err  output  1  one-cycle pulse on alignment violation.
- locked  output  1  high while in RUN state.

Behaviour:
- Reset (rst=1 at clock edge):
  - out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0.
  - ch_cnt=0, state=HUNT.
  - rst overrides any simultaneous beat; a beat in the reset cycle is dropped.
- Counter: ch_cnt is $clog2(NUM_CH) bits and wraps from NUM_CH-1 to 0. It advances only on accepted beats.
- Latency: a beat accepted at edge t appears on out_data/out_valid/frame_done/sync_err after edge t, i.e. one cycle.
- Strobes: all pulses are single-cycle and default to 0 every cycle with no event. Only untouched channels hold their out_data.
- Idle: in_valid=0 changes no state and no data. Gaps between beats are allowed anywhere in a frame.
- State HUNT (locked=0):
  - Beat with in_sof=0: dropped, no output, no sync_err.
  - Beat with in_sof=1: write channel 0, pulse out_valid[0], ch_cnt←1, state←RUN.
- State RUN (locked=1):
  - ch_cnt≠0, in_sof=0: write channel ch_cnt, pulse out_valid[ch_cnt], ch_cnt advances. If ch_cnt was NUM_CH-1, also pulse frame_done.
  - ch_cnt=0, in_sof=1: normal frame start; write channel 0, ch_cnt←1.
  - ch_cnt≠0, in_sof=1 (early sof, short frame): pulse sync_err, resync by writing channel 0, ch_cnt←1, stay RUN. No frame_done for the truncated frame.
  - ch_cnt=0, in_sof=0 (missing sof, long frame): pulse sync_err, drop beat, ch_cnt stays 0, state←HUNT, locked falls.
- Within a frame, channels update in strict order 0..NUM_CH-1. No channel is written twice per frame.
- out_valid is one-hot or zero at all times.

Test Plan:
- Reset, then frame A0,A1,A2,A3 (sof on A0), one beat per cycle -> out_valid 0001,0010,0100,1000 on consecutive cycles; frame_done with last; out_data=A3A2A1A0; locked=1 after first beat.
- After reset, beats 0x11,0x22 with sof=0, then 0x33 with sof=1 -> first two dropped, no sync_err; ch0=0x33, locked=1.
- Locked, frame 10,20 then sof on 0x55 -> sync_err pulses with out_valid[0]; ch0=0x55; next beat 0x66 goes to ch1; ch2/ch3 hold previous values; no frame_done for the truncated frame.
- Complete frame, then beat 0x77 with sof=0 -> sync_err, locked=0, out_data unchanged; next beat with sof relocks to ch0.
- Frame with in_valid gaps (valid pattern 1,0,0,1,1,0,1) -> same outputs as back-to-back; strobes only one cycle after valid beats.
- Assert rst in the cycle of beat ch2 mid-frame -> beat dropped, all outputs 0, locked=0; the following frame decodes correctly.
